mem_arbiter: RTL
================

# mem_arbiter

Sequencing arbiter that shares one single-port synchronous memory between the CPU's instruction-fetch path (driven by the program counter) and its load/store path (driven by the ALU result and register rs2 data). It grants one requester at a time and runs the memory access through a fixed-latency state machine. It returns read data with a one-cycle valid pulse and drives a stall line that freezes the core while any access is pending. It sits between the core and the unified memory, replacing the separate instruction and data memory instances.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..8

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch grant (combinational, IDLE only)
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data grant (combinational, IDLE only)
- d_rvalid  out  1  one-cycle pulse; load data valid or store complete
- d_rdata  out  DATA_W  load data; 0 for stores
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data
- stall  out  1  = (state != IDLE) | if_req | d_req

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitrates among the asserted requests.
  - Asserts the winner's gnt combinationally in the same cycle.
  - Captures the winner's addr, we and wdata, plus the owner bit.
  - Moves to ISSUE.
  - With no request, stays in IDLE.
- ISSUE, one cycle:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the captured values.
  - Loads wait counter with MEM_LAT-1, then moves to WAIT.
- WAIT, MEM_LAT cycles:
  - mem_en=0.
  - On the last cycle (counter==0), registers mem_rdata into the owner's rdata, or 0 for a store, then moves to RESP.
- RESP, one cycle:
  - Owner's rvalid=1; rdata holds until overwritten by the next response to that owner.
  - Moves to IDLE.
- Grants are issued only in IDLE. Requests arriving in any other state wait.
- Inputs are sampled only at grant. Later changes to addr, we or wdata do not affect the transaction.
- A request dropped before its grant produces no transaction (legal).
- Default arbitration is fixed priority: data beats fetch.
- Reset, asynchronous:
  - State goes to IDLE; counter, captured fields and every output register go to 0.
  - An in-flight access is abandoned: no rvalid, mem_en drops immediately.
  - Reset values: if_gnt=d_gnt=0 (no requests while in reset), if_rvalid=d_rvalid=0, if_rdata=d_rdata=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, stall=0.

## Timing
- Grant in cycle 0 → mem_en in cycle 1 → mem_rdata sampled in cycle 1+MEM_LAT → rvalid in cycle 2+MEM_LAT → IDLE in cycle 3+MEM_LAT.
- Next grant no earlier than cycle 3+MEM_LAT.
- Throughput: one access per 3+MEM_LAT cycles.
- Store ack timing is identical to load timing.
- stall is high from the first cycle a request is asserted through RESP inclusive. It drops in the IDLE cycle after RESP unless a new request is present.
- If both requests are asserted in IDLE, exactly one gnt rises. The loser's gnt stays 0 until the next IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Adds a last-winner register, reset value = data.
  - On a tie in IDLE, the requester that did not win last is granted; the first tie after reset goes to fetch.
  - Uncontested grants also update last-winner.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, data wins every tie, and no last-winner register exists.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0. Release, then idle 5 cycles → mem_en never asserts.
- Fetch, MEM_LAT=1, memory word @0x10 = 0x00500093: if_req, if_addr=0x10 at cycle 0 → if_gnt cycle 0; mem_en=1, mem_addr=0x10 cycle 1; if_rvalid=1, if_rdata=0x00500093 cycle 3; stall low cycle 4.
- Store then load, MEM_LAT=2: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → mem_we=1 cycle 1, d_rvalid cycle 4 with d_rdata=0. Then load 0x40 → d_rdata=0xDEADBEEF.
- Tie, macro off, MEM_LAT=1: if_req and d_req at cycle 0 → d_gnt cycle 0, if_gnt cycle 4, if_rvalid cycle 7.
- Tie, ARB_ROUND_ROBIN_EN on: both requesters held continuously for 3 grants → order fetch, data, fetch.
- Reset mid-access, MEM_LAT=4: fetch granted cycle 0, rst=0 during cycle 3 → mem_en=0 immediately, no if_rvalid. After release, a new fetch completes with normal timing.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous memory between fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build gives data priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_owner;
    logic               r_we;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_d_rdata;
    logic               w_idle;
    logic               w_pick_d;
    logic               w_pick_if;
    logic               w_grant;
    logic               w_last_wait;

    // Gating with rst keeps grants and stall low while reset is held.
    assign w_idle = (r_state == IDLE) && rst;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;

    assign w_pick_d = d_req && (!if_req || !r_last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= 1'b1;
        end else if (w_grant) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = d_req;
`endif

    assign w_pick_if   = if_req && !w_pick_d;
    assign d_gnt       = w_idle && w_pick_d;
    assign if_gnt      = w_idle && w_pick_if;
    assign w_grant     = d_gnt || if_gnt;
    assign w_last_wait = (r_state == WAIT) && (r_cnt == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // mem_en/mem_we are high only in ISSUE; address and data hold until the next grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_en <= w_grant;
            r_mem_we <= d_gnt && d_we;
            if (w_grant) begin
                r_owner     <= w_pick_d;
                r_we        <= w_pick_d && d_we;
                r_mem_addr  <= w_pick_d ? d_addr : if_addr;
                r_mem_wdata <= w_pick_d ? d_wdata : '0;
            end
            if (r_state == ISSUE) begin
                r_cnt <= CNT_W'(MEM_LAT - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last_wait) begin
                if (r_owner) begin
                    r_d_rdata <= r_we ? '0 : mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_rvalid = (r_state == RESP) && !r_owner;
    assign d_rvalid  = (r_state == RESP) && r_owner;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall     = rst && ((r_state != IDLE) || if_req || d_req);

endmodule
